// File: rtl/crc32_stream_engine.sv
// rtl/crc32_stream_engine.sv - reflected CRC-32 stream engine, slicing-by-4 fold, 2-stage pipeline
// Define CRC_FRAME_CNT_EN to add the 16-bit frame_cnt output counting CRC handshakes.
module crc32_stream_engine #(
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic [1:0]  s_nbytes,
    output logic        crc_valid,
    input  logic        crc_ready,
`ifdef CRC_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic [31:0] crc_out
);
    localparam logic [31:0] POLY = 32'hEDB88320;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

    // Entry b of table k: contribution of byte b followed by k zero bytes.
    function automatic logic [31:0] tbl_entry(input int k, input int b);
        logic [31:0] c;
        c = 32'(b);
        for (int i = 0; i < 8 * (k + 1); i++)
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        return c;
    endfunction

    logic [31:0] tbl [4][256];

    for (genvar k = 0; k < 4; k++) begin : g_tbl
        for (genvar b = 0; b < 256; b++) begin : g_ent
            localparam logic [31:0] ENT = tbl_entry(k, b);
            assign tbl[k][b] = ENT;
        end
    end

    state_t      state;
    state_t      state_nxt;
    logic        ready_en;
    logic        accept;
    logic        s1_valid;
    logic        s1_last;
    logic [31:0] s1_data;
    logic [1:0]  s1_nbytes;
    logic [31:0] acc;
    logic [1:0]  last_idx;
    logic [1:0]  j;
    logic [2:0]  nb;
    logic [31:0] x;
    logic [31:0] fold;

    assign accept  = s_valid && s_ready;
    assign crc_out = acc ^ XOROUT;

    // s_ready stays low while reset is asserted and rises on the first edge after release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_data   <= '0;
            s1_nbytes <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data   <= s_data;
                s1_last   <= s_last;
                s1_nbytes <= s_last ? s_nbytes : 2'd0;
            end
        end
    end

    // Fold the low nb bytes: table k takes byte (nb-1-k), untouched crc bytes shift down.
    always_comb begin
        last_idx = s1_nbytes - 2'd1;
        nb       = {1'b0, last_idx} + 3'd1;
        x        = acc ^ s1_data;
        fold     = acc >> {nb, 3'b000};
        j        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            j = last_idx - 2'(k);
            if (2'(k) <= last_idx)
                fold = fold ^ tbl[k][x[{j, 3'b000} +: 8]];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                         acc <= INIT;
        else if (state == HOLD && crc_ready) acc <= INIT;
        else if (s1_valid)                 acc <= fold;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (s1_valid && s1_last)    state_nxt = HOLD;
                else if (accept && !s_last) state_nxt = ACCUM;
            end
            ACCUM: if (s1_valid && s1_last) state_nxt = HOLD;
            HOLD:  if (crc_ready)           state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        crc_valid = (state == HOLD);
        s_ready   = ready_en && (state != HOLD) && !(s1_valid && s1_last);
    end

`ifdef CRC_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                       frame_cnt <= '0;
        else if (crc_valid && crc_ready) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_crc32_stream_engine.sv
// tb/tb_crc32_stream_engine.sv - self-checking bench for crc32_stream_engine against a bitwise CRC model
// Define CRC_FRAME_CNT_EN to also exercise the frame counter.
module tb_crc32_stream_engine;
    localparam logic [31:0] INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] XOROUT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [1:0]  s_nbytes;
    logic        crc_valid;
    logic        crc_ready;
    logic [31:0] crc_out;
`ifdef CRC_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int hs_count     = 0;
    logic [31:0] last_hs_crc = '0;

    logic [31:0] fw [$];
    logic [1:0]  f_nb;

    crc32_stream_engine #(.INIT(INIT), .XOROUT(XOROUT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_nbytes  (s_nbytes),
        .crc_valid (crc_valid),
        .crc_ready (crc_ready),
`ifdef CRC_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .crc_out   (crc_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (crc_valid && crc_ready) begin
            hs_count    <= hs_count + 1;
            last_hs_crc <= crc_out;
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish (run %0d, failed %0d)", tests_run, tests_failed);
        $fatal(1);
    end

    // Bit-serial reflected CRC-32 over the byte stream of the frame held in fw / f_nb.
    function automatic logic [31:0] model_crc();
        logic [31:0] c;
        int n;
        c = INIT;
        for (int i = 0; i < fw.size(); i++) begin
            n = (i == fw.size() - 1) ? ((f_nb == 2'd0) ? 4 : int'(f_nb)) : 4;
            for (int b = 0; b < n; b++) begin
                c = c ^ {24'd0, fw[i][8*b +: 8]};
                for (int t = 0; t < 8; t++)
                    c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c ^ XOROUT;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] nb, output int waited);
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = l;
        s_nbytes = nb;
        waited   = 0;
        while (s_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, waited);
        end
        @(posedge clk); #1;
        s_valid  = 1'b0;
        s_data   = $urandom;
        s_last   = 1'($urandom);
        s_nbytes = 2'($urandom);
    endtask

    task automatic do_frame(input int gap_max, input int hold, input logic [31:0] exp, input string name);
        int w;
        crc_ready = (hold == 0);
        for (int i = 0; i < fw.size(); i++) begin
            if (gap_max > 0)
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            send_word(fw[i], i == fw.size() - 1, (i == fw.size() - 1) ? f_nb : 2'($urandom), w);
        end
        tests_run++;
        if (crc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s early_valid: crc_valid=%b one cycle after last, required 0", name, crc_valid);
        end
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s ready_after_last: s_ready=%b, required 0", name, s_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (crc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s latency: crc_valid=%b two cycles after last, required 1", name, crc_valid);
        end
        tests_run++;
        if (crc_out !== exp) begin
            tests_failed++;
            $display("FAIL %s crc: crc_out=%h, required %h", name, crc_out, exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            tests_run++;
            if (crc_valid !== 1'b1 || crc_out !== exp || s_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s hold[%0d]: valid=%b crc=%h ready=%b, required 1 %h 0",
                         name, h, crc_valid, crc_out, s_ready, exp);
            end
        end
        crc_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (crc_valid !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s release: valid=%b ready=%b, required 0 1", name, crc_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = 2'd0; crc_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        tests_run++;
        if (s_ready !== 1'b0 || crc_valid !== 1'b0 || crc_out !== (INIT ^ XOROUT)) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b valid=%b crc=%h, required 0 0 %h",
                     s_ready, crc_valid, crc_out, INIT ^ XOROUT);
        end
        rstn = 1'b1; #1;
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_early: s_ready=%b, required 0", s_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_edge: s_ready=%b, required 1", s_ready);
        end
    endtask

    task automatic test_check_value();
        fw = '{32'h34333231, 32'h38373635, 32'h00000039}; f_nb = 2'd1;
        do_frame(0, 0, 32'hCBF43926, "check_123456789");
    endtask

    task automatic test_partial();
        fw = '{32'h00000000}; f_nb = 2'd0;
        do_frame(0, 0, 32'h2144DF1C, "one_word_zero");
        fw = '{32'hFF636261}; f_nb = 2'd3;
        do_frame(0, 0, 32'h352441C2, "partial_abc");
    endtask

    task automatic test_hold();
        int w;
        fw = '{32'h00000061}; f_nb = 2'd1;
        do_frame(0, 5, 32'hE8B7BE43, "hold_a");
        send_word(32'h00000000, 1'b1, 2'd0, w);
        tests_run++;
        if (w !== 0) begin
            tests_failed++;
            $display("FAIL hold_next_accept: waited %0d cycles, required 0", w);
        end
        @(posedge clk); #1;
        tests_run++;
        if (crc_valid !== 1'b1 || crc_out !== 32'h2144DF1C) begin
            tests_failed++;
            $display("FAIL hold_next_crc: valid=%b crc=%h, required 1 2144df1c", crc_valid, crc_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        fw = '{32'h34333231, 32'h38373635, 32'h00000039}; f_nb = 2'd1;
        for (int r = 0; r < 3; r++)
            do_frame(3, 0, 32'hCBF43926, "gaps_123456789");
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int hs0;
        hs0 = hs_count;
        send_word(32'h34333231, 1'b0, 2'd0, w);
        send_word(32'h38373635, 1'b0, 2'd0, w);
        rstn = 1'b0; #1;
        tests_run++;
        if (crc_valid !== 1'b0 || s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_state: valid=%b ready=%b, required 0 0", crc_valid, s_ready);
        end
        repeat (2) @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        fw = '{32'h34333231, 32'h38373635, 32'h00000039}; f_nb = 2'd1;
        do_frame(0, 0, 32'hCBF43926, "reset_mid_resend");
        tests_run++;
        if (hs_count !== hs0 + 1 || last_hs_crc !== 32'hCBF43926) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: handshakes=%0d crc=%h, required 1 cbf43926",
                     hs_count - hs0, last_hs_crc);
        end
    endtask

    task automatic test_reset_in_hold();
        int w;
        int hs0;
        hs0 = hs_count;
        crc_ready = 1'b0;
        send_word(32'h00000061, 1'b1, 2'd1, w);
        @(posedge clk); #1;
        tests_run++;
        if (crc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_hold_pre: crc_valid=%b, required 1", crc_valid);
        end
        rstn = 1'b0; #1;
        tests_run++;
        if (crc_valid !== 1'b0 || crc_out !== (INIT ^ XOROUT)) begin
            tests_failed++;
            $display("FAIL reset_hold_clear: valid=%b crc=%h, required 0 %h", crc_valid, crc_out, INIT ^ XOROUT);
        end
        crc_ready = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (hs_count !== hs0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_hold_after: handshakes=%0d ready=%b, required 0 1", hs_count - hs0, s_ready);
        end
    endtask

    task automatic test_random_frames();
        int len;
        for (int f = 0; f < 40; f++) begin
            fw.delete();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) fw.push_back($urandom);
            f_nb = 2'($urandom_range(0, 3));
            do_frame(($urandom_range(0, 1) == 1) ? 2 : 0, $urandom_range(0, 2), model_crc(), "random");
        end
    endtask

`ifdef CRC_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int w;
        rstn = 1'b0; crc_ready = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int f = 0; f < 32'h10001; f++) begin
            send_word($urandom, 1'b1, 2'd0, w);
            repeat (2) begin @(posedge clk); #1; end
        end
        tests_run++;
        if (frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL frame_cnt_wrap: frame_cnt=%h, required 0001", frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_check_value();
        test_partial();
        test_hold();
        test_gaps();
        test_reset_mid_frame();
        test_reset_in_hold();
        test_random_frames();
`ifdef CRC_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/crc32_stream_engine.md
CRC32_STREAM_ENGINE -- requirements
Module: crc32_stream_engine

Interface
REQ-001 Parameter: INIT, 32'hFFFFFFFF, CRC register preset at start of frame.
REQ-002 Parameter: XOROUT, 32'hFFFFFFFF, value XORed onto the final CRC.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  input word valid.
REQ-006 s_ready  output  1  engine accepts a word when s_valid && s_ready.
REQ-007 s_data  input  32  payload word; byte 0 = s_data[7:0] is first on the wire.
REQ-008 s_last  input  1  marks the final word of a frame.
REQ-009 s_nbytes  input  2  valid bytes in the last word: 0 means 4, 1-3 means 1-3 low-order bytes; ignored when s_last=0.
REQ-010 crc_valid  output  1  final CRC available.
REQ-011 crc_ready  input  1  consumer accepts CRC when crc_valid && crc_ready.
REQ-012 crc_out  output  32  final CRC of the frame.

Function
REQ-013 The engine SHALL compute reflected CRC-32: poly 0xEDB88320, init INIT, reflected in/out, final XOR XOROUT.
REQ-014 Full words SHALL be folded in one cycle by slicing-by-4: four 256x32 lookup tables indexed by (crc ^ data) bytes, results XORed with crc>>32.
REQ-015 A partial last word SHALL fold only its s_nbytes low bytes, byte 0 first; upper bytes SHALL NOT affect the result.
REQ-016 The engine SHALL implement a 2-stage pipeline: stage 1 registers the accepted word, last flag and byte count; stage 2 updates the CRC accumulator.
REQ-017 The FSM SHALL have the states IDLE (accumulator = INIT), ACCUM (mid-frame) and HOLD (crc_valid=1, awaiting crc_ready).
REQ-018 IDLE->ACCUM SHALL occur on the first accepted word with s_last=0; ACCUM->HOLD and IDLE->HOLD SHALL occur when stage 2 folds a last word; HOLD->IDLE SHALL occur on crc_valid && crc_ready.
REQ-019 crc_valid SHALL assert exactly 2 cycles after the handshake of the last word.
REQ-020 crc_out SHALL equal accumulator ^ XOROUT and SHALL remain stable while crc_valid=1.
REQ-021 s_ready SHALL be 1 except while in HOLD or while stage 1 holds a last word.
REQ-022 Throughput SHALL be one word per cycle within a frame; a one-word frame SHALL be legal.
REQ-023 On the HOLD->IDLE cycle the accumulator SHALL reload INIT, so a new frame's first word SHALL be accepted on the next cycle.
REQ-024 A dropped s_valid mid-frame SHALL create a bubble only; the accumulator SHALL be preserved.

Reset
REQ-025 While rstn=0: state=IDLE, accumulator=INIT, stage-1 valid=0, crc_valid=0, crc_out=INIT^XOROUT, s_ready=0.
REQ-026 s_ready SHALL assert on the first clock edge after rstn deasserts.
REQ-027 Reset mid-frame or in HOLD SHALL discard the partial frame with no CRC output.

Configuration
REQ-028 With CRC_FRAME_CNT_EN defined, the engine SHALL add the port frame_cnt (output, 16) counting CRC handshakes, reset to 0 and wrapping 0xFFFF->0.
REQ-029 With CRC_FRAME_CNT_EN undefined, the port and the counter SHALL be absent and there SHALL be no other behavioural change.

Verification
REQ-030 Send words 0x34333231, 0x38373635, then 0x00000039 with s_last=1 and s_nbytes=1 -> crc_out=0xCBF43926 two cycles after the last handshake.
REQ-031 Send a one-word frame 0x00000000 with s_nbytes=0 -> crc_out=0x2144DF1C; send 0xFF636261 with s_nbytes=3 ("abc") -> crc_out=0x352441C2.
REQ-032 Send 0x00000061 with s_nbytes=1, hold crc_ready=0 for 5 cycles -> crc_out=0xE8B7BE43 stable and s_ready=0 throughout; the next frame is accepted on the cycle after release.
REQ-033 Send the REQ-030 frame with s_valid gaps between words -> same 0xCBF43926.
REQ-034 Assert rstn=0 after the second word of the REQ-030 frame, then resend the full frame -> the only CRC output is 0xCBF43926.
REQ-035 With CRC_FRAME_CNT_EN, run 0x10001 frames -> frame_cnt=1.
